regwr_port_arbiter: RTL and testbench

// - Shares the single register-file write port among 4 requesters (ALU, load unit, link/JAL, spare).
// - Picks one request per cycle, drives the 2-bit select of the 5-bit write-address mux4x1, and registers the granted address and data into the register file.
// - Sits between the execute/writeback sources and the register file.

---
 rtl/regwr_pkg.sv | 23 ++
 rtl/regwr_port_arbiter_if.sv | 36 +++
 rtl/mux4x1.sv | 25 ++
 rtl/regwr_port_arbiter.sv | 107 ++++++++++
 tb/tb_regwr_port_arbiter.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/regwr_pkg.sv
// Shared constants for the register-file write-port arbiter.
package regwr_pkg;

    localparam int unsigned NUM_WR_SRC   = 4;
    localparam int unsigned WR_SRC_ALU   = 0;
    localparam int unsigned WR_SRC_LD    = 1;
    localparam int unsigned WR_SRC_LINK  = 2;
    localparam int unsigned WR_SRC_SPARE = 3;

    localparam int unsigned REG_ADDR_W   = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    // Number of set bits in a request vector.
    function automatic logic [2:0] req_count(input logic [NUM_WR_SRC-1:0] r);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < NUM_WR_SRC; i++) begin
            n = n + 3'(r[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/regwr_port_arbiter_if.sv
// Requester-side and register-file-side signals of the write-port arbiter.
interface regwr_port_arbiter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 16
);
    import regwr_pkg::*;

    logic                  hold;
    logic [NUM_WR_SRC-1:0] req;
    logic [ADDR_W-1:0]     addr0;
    logic [ADDR_W-1:0]     addr1;
    logic [ADDR_W-1:0]     addr2;
    logic [ADDR_W-1:0]     addr3;
    logic [DATA_W-1:0]     data0;
    logic [DATA_W-1:0]     data1;
    logic [DATA_W-1:0]     data2;
    logic [DATA_W-1:0]     data3;
    logic [NUM_WR_SRC-1:0] gnt;
    logic [1:0]            sel;
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_W-1:0]     wr_data;
    logic [CNT_W-1:0]      contend_cnt;

    modport master (
        output hold, req, addr0, addr1, addr2, addr3, data0, data1, data2, data3,
        input  gnt, sel, wr_en, wr_addr, wr_data, contend_cnt
    );

    modport slave (
        input  hold, req, addr0, addr1, addr2, addr3, data0, data1, data2, data3,
        output gnt, sel, wr_en, wr_addr, wr_data, contend_cnt
    );

endinterface

// File: rtl/mux4x1.sv
// Generic 4-to-1 multiplexer used on the write-address path.
module mux4x1 #(
    parameter int unsigned W = 5
) (
    input  logic [1:0]   sel,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    output logic [W-1:0] y
);

    // Select one of four inputs.
    always_comb begin
        y = d0;
        case (sel)
            2'd0: y = d0;
            2'd1: y = d1;
            2'd2: y = d2;
            2'd3: y = d3;
            default: y = d0;
        endcase
    end

endmodule

// File: rtl/regwr_port_arbiter.sv
// Arbitrates the single register-file write port among four sources and
// registers the winning address/data toward the register file.
module regwr_port_arbiter
    import regwr_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter bit          RR_MODE = 1'b1,
    parameter bit          DROP_R0 = 1'b1,
    parameter int unsigned CNT_W   = 16
) (
    input logic               clk,
    input logic               rst,
    regwr_port_arbiter_if.slave bus
);

    logic [1:0]            ptr;
    logic [1:0]            scan_start;
    logic [1:0]            scan_idx;
    logic                  grant_vld;
    logic [1:0]            sel_c;
    logic [NUM_WR_SRC-1:0] gnt_c;
    logic [ADDR_W-1:0]     mux_addr;
    logic [DATA_W-1:0]     mux_data;
    logic                  contended;
    logic                  wr_en_q;
    logic [ADDR_W-1:0]     wr_addr_q;
    logic [DATA_W-1:0]     wr_data_q;
    logic [CNT_W-1:0]      contend_q;

    // Rotating priority encoder: first request at or after the scan start.
    always_comb begin
        gnt_c      = '0;
        sel_c      = 2'd0;
        grant_vld  = 1'b0;
        scan_idx   = 2'd0;
        scan_start = RR_MODE ? ptr : 2'd0;
        if (!rst && !bus.hold && (|bus.req)) begin
            for (int i = 0; i < NUM_WR_SRC; i++) begin
                scan_idx = scan_start + 2'(i);
                if (!grant_vld && bus.req[scan_idx]) begin
                    grant_vld       = 1'b1;
                    sel_c           = scan_idx;
                    gnt_c[scan_idx] = 1'b1;
                end
            end
        end
    end

    // Address path through the shared mux.
    mux4x1 #(.W(ADDR_W)) u_addr_mux (
        .sel (sel_c),
        .d0  (bus.addr0),
        .d1  (bus.addr1),
        .d2  (bus.addr2),
        .d3  (bus.addr3),
        .y   (mux_addr)
    );

    // Write-data selection of the winner.
    always_comb begin
        mux_data = bus.data0;
        case (sel_c)
            2'd0: mux_data = bus.data0;
            2'd1: mux_data = bus.data1;
            2'd2: mux_data = bus.data2;
            2'd3: mux_data = bus.data3;
            default: mux_data = bus.data0;
        endcase
    end

    // Cycle counts as contended when two or more sources want the port.
    always_comb begin
        contended = !bus.hold && (req_count(bus.req) >= 3'd2);
    end

    // Pointer, registered write port and contention counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= 2'd0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            contend_q <= '0;
        end else begin
            if (grant_vld) begin
                ptr       <= sel_c + 2'd1;
                wr_en_q   <= !(DROP_R0 && (mux_addr == ADDR_W'(REG_ZERO)));
                wr_addr_q <= mux_addr;
                wr_data_q <= mux_data;
            end else begin
                wr_en_q   <= 1'b0;
            end
            if (contended && (contend_q != {CNT_W{1'b1}})) begin
                contend_q <= contend_q + CNT_W'(1);
            end
        end
    end

    assign bus.gnt         = gnt_c;
    assign bus.sel         = sel_c;
    assign bus.wr_en       = wr_en_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.contend_cnt = contend_q;

endmodule

// File: tb/tb_regwr_port_arbiter.sv
// Directed bench: one round-robin arbiter and one fixed-priority arbiter
// (narrow counter) driven by the same stimulus.
module tb_regwr_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        hold;
    logic [3:0]  req;
    logic [4:0]  addr0, addr1, addr2, addr3;
    logic [31:0] data0, data1, data2, data3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regwr_port_arbiter_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) bus_rr ();
    regwr_port_arbiter_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(3))  bus_fp ();

    assign bus_rr.hold = hold;   assign bus_fp.hold = hold;
    assign bus_rr.req  = req;    assign bus_fp.req  = req;
    assign bus_rr.addr0 = addr0; assign bus_fp.addr0 = addr0;
    assign bus_rr.addr1 = addr1; assign bus_fp.addr1 = addr1;
    assign bus_rr.addr2 = addr2; assign bus_fp.addr2 = addr2;
    assign bus_rr.addr3 = addr3; assign bus_fp.addr3 = addr3;
    assign bus_rr.data0 = data0; assign bus_fp.data0 = data0;
    assign bus_rr.data1 = data1; assign bus_fp.data1 = data1;
    assign bus_rr.data2 = data2; assign bus_fp.data2 = data2;
    assign bus_rr.data3 = data3; assign bus_fp.data3 = data3;

    regwr_port_arbiter #(.DATA_W(32), .ADDR_W(5), .RR_MODE(1'b1), .DROP_R0(1'b1), .CNT_W(16))
        u_rr (.clk(clk), .rst(rst), .bus(bus_rr.slave));

    regwr_port_arbiter #(.DATA_W(32), .ADDR_W(5), .RR_MODE(1'b0), .DROP_R0(1'b1), .CNT_W(3))
        u_fp (.clk(clk), .rst(rst), .bus(bus_fp.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [4:0]  exp_addr [4];
    logic [31:0] exp_data [4];

    initial begin
        rst  = 1'b1;
        hold = 1'b0;
        req  = 4'b1111;
        addr0 = 5'd3;  addr1 = 5'd5;  addr2 = 5'd7;  addr3 = 5'd9;
        data0 = 32'hA000_0000; data1 = 32'hA111_1111;
        data2 = 32'hA222_2222; data3 = 32'hA333_3333;
        exp_addr[0] = 5'd3; exp_addr[1] = 5'd5; exp_addr[2] = 5'd7; exp_addr[3] = 5'd9;
        exp_data[0] = 32'hA000_0000; exp_data[1] = 32'hA111_1111;
        exp_data[2] = 32'hA222_2222; exp_data[3] = 32'hA333_3333;

        // Reset held for two edges with every request pending.
        tick();
        tick();
        chk("rst_gnt",     32'(bus_rr.gnt), 32'h0);
        chk("rst_sel",     32'(bus_rr.sel), 32'h0);
        chk("rst_wr_en",   32'(bus_rr.wr_en), 32'h0);
        chk("rst_wr_addr", 32'(bus_rr.wr_addr), 32'h0);
        chk("rst_wr_data", bus_rr.wr_data, 32'h0);
        chk("rst_cnt",     32'(bus_rr.contend_cnt), 32'h0);

        // Round robin over all four requesters for eight cycles.
        rst = 1'b0;
        #1;
        chk("fp_gnt_all", 32'(bus_fp.gnt), 32'h1);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("rr_gnt_%0d", k), 32'(bus_rr.gnt), 32'(4'b0001 << (k % 4)));
            tick();
            chk($sformatf("rr_wr_en_%0d", k), 32'(bus_rr.wr_en), 32'h1);
            chk($sformatf("rr_wr_addr_%0d", k), 32'(bus_rr.wr_addr), 32'(exp_addr[k % 4]));
            chk($sformatf("rr_wr_data_%0d", k), bus_rr.wr_data, exp_data[k % 4]);
        end
        req = 4'b0000;
        #1;
        chk("rr_cnt_8",  32'(bus_rr.contend_cnt), 32'd8);
        chk("fp_cnt_sat", 32'(bus_fp.contend_cnt), 32'd7);
        chk("idle_gnt",  32'(bus_rr.gnt), 32'h0);

        // Single requester on the link port.
        req   = 4'b0100;
        addr2 = 5'd7;
        data2 = 32'hDEAD_BEEF;
        #1;
        chk("single_gnt", 32'(bus_rr.gnt), 32'h4);
        chk("single_sel", 32'(bus_rr.sel), 32'd2);
        tick();
        req = 4'b0000;
        chk("single_wr_en",   32'(bus_rr.wr_en), 32'h1);
        chk("single_wr_addr", 32'(bus_rr.wr_addr), 32'd7);
        chk("single_wr_data", bus_rr.wr_data, 32'hDEAD_BEEF);
        chk("single_ptr",     32'(u_rr.ptr), 32'd3);

        // Stall with a pending request: no grant, pointer and counter frozen.
        hold = 1'b1;
        req  = 4'b0001;
        #1;
        chk("hold_gnt", 32'(bus_rr.gnt), 32'h0);
        tick();
        chk("hold_wr_en_1", 32'(bus_rr.wr_en), 32'h0);
        tick();
        chk("hold_wr_en_2", 32'(bus_rr.wr_en), 32'h0);
        chk("hold_ptr",     32'(u_rr.ptr), 32'd3);
        chk("hold_cnt",     32'(bus_rr.contend_cnt), 32'd8);
        hold = 1'b0;
        #1;
        chk("unhold_gnt", 32'(bus_rr.gnt), 32'h1);
        tick();
        chk("unhold_wr_en",   32'(bus_rr.wr_en), 32'h1);
        chk("unhold_wr_addr", 32'(bus_rr.wr_addr), 32'd3);

        // Write to register zero is granted but suppressed.
        addr0 = 5'd0;
        data0 = 32'h1234_5678;
        #1;
        chk("r0_gnt", 32'(bus_rr.gnt), 32'h1);
        tick();
        chk("r0_wr_en",   32'(bus_rr.wr_en), 32'h0);
        chk("r0_fp_wr_en", 32'(bus_fp.wr_en), 32'h0);
        req   = 4'b0000;
        addr0 = 5'd3;
        data0 = 32'hA000_0000;
        tick();

        // Fixed priority: requester 1 always beats requester 3.
        req = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("fp_gnt_%0d", k), 32'(bus_fp.gnt), 32'h2);
            chk($sformatf("fp_sel_%0d", k), 32'(bus_fp.sel), 32'd1);
            tick();
            chk($sformatf("fp_wr_addr_%0d", k), 32'(bus_fp.wr_addr), 32'd5);
        end
        req = 4'b0000;
        #1;
        chk("fp_cnt_hold_sat", 32'(bus_fp.contend_cnt), 32'd7);
        chk("rr_cnt_11",       32'(bus_rr.contend_cnt), 32'd11);

        // Mid-operation reset right after a grant to requester 1.
        req = 4'b0010;
        #1;
        chk("mid_gnt", 32'(bus_rr.gnt), 32'h2);
        tick();
        chk("mid_ptr",   32'(u_rr.ptr), 32'd2);
        chk("mid_wr_en", 32'(bus_rr.wr_en), 32'h1);
        rst = 1'b1;
        #1;
        chk("mid_rst_gnt", 32'(bus_rr.gnt), 32'h0);
        tick();
        chk("mid_rst_wr_en", 32'(bus_rr.wr_en), 32'h0);
        chk("mid_rst_ptr",   32'(u_rr.ptr), 32'd0);
        chk("mid_rst_cnt",   32'(bus_rr.contend_cnt), 32'd0);
        rst = 1'b0;
        req = 4'b0011;
        #1;
        chk("post_rst_gnt", 32'(bus_rr.gnt), 32'h1);
        tick();
        req = 4'b0000;
        chk("post_rst_wr_addr", 32'(bus_rr.wr_addr), 32'd3);
        chk("post_rst_cnt",     32'(bus_rr.contend_cnt), 32'd1);
        chk("post_rst_ptr",     32'(u_rr.ptr), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
